ex_stage: RTL

Execute stage of the five-stage pipelined CPU. It contains the ID/EX pipeline register, the ALU, the branch-target adder, jump-target formation and an optional iterative multiplier with a stall handshake. It sits between the decode stage and the memory stage. Its outputs are unregistered and are captured by the memory stage's EX/MEM register on the next CLK edge. The memory stage's `flush` returns here to squash the instruction currently in execute.

---
 rtl/ex_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: ID/EX pipeline register, ALU, branch/jump target formation and optional multiplier.
// Build option EX_MULDIV_EN: adds the iterative shift-add multiplier with its stall handshake.
//
// state | meaning (multiplier FSM, EX_MULDIV_EN only)
// IDLE  | no multiply in flight; a MUL in execute starts one and raises stall
// MUL   | one shift-add step per cycle, down-counter runs 31..0, stall held
// DONE  | product on ALUOut_out, stall released, next instruction loads on exit
module ex_stage (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        flush,
   input  logic        RegWriteD,
   input  logic        MemtoRegD,
   input  logic        MemWriteD,
   input  logic        BranchD,
   input  logic        JumpD,
   input  logic        ALUSrcD,
   input  logic [5:0]  ALUopD,
   input  logic [31:0] RegData1_in,
   input  logic [31:0] RegData2_in,
   input  logic [31:0] SignImm_in,
   input  logic [4:0]  shamt_in,
   input  logic [31:0] PCPlus4_in,
   input  logic [4:0]  wb_addr_in,
   output logic        RegWriteE,
   output logic        MemtoRegE,
   output logic        MemWriteE,
   output logic        BranchE,
   output logic        JumpE,
   output logic [5:0]  ALUopE,
   output logic [31:0] ALUOut_out,
   output logic [31:0] WriteData_out,
   output logic [31:0] PCBranch_out,
   output logic [31:0] PCPlus4_out,
   output logic [4:0]  wb_addr_out,
   output logic        stall
);
   localparam logic [5:0] OP_ADD = 6'h01, OP_SUB = 6'h02, OP_AND = 6'h03, OP_OR  = 6'h04;
   localparam logic [5:0] OP_XOR = 6'h05, OP_NOR = 6'h06, OP_SLT = 6'h07, OP_SLL = 6'h08;
   localparam logic [5:0] OP_SRL = 6'h09, OP_SRA = 6'h0A, OP_BEQ = 6'h0B, OP_BNE = 6'h0C;
   localparam logic [5:0] OP_J   = 6'h0D, OP_JR  = 6'h0E, OP_JAL = 6'h0F, OP_MUL = 6'h10;

   logic        reg_write_e, mem_to_reg_e, mem_write_e, branch_e, jump_e, alu_src_e;
   logic [5:0]  alu_op_e;
   logic [31:0] rd1_e, rd2_e, imm_e, pc4_e;
   logic [4:0]  shamt_e, wb_addr_e;
   logic [31:0] src_b, alu_out, mul_result;
   logic        mul_done;

   // Flush wins over stall so a squashed multiply cannot be held in execute.
   always_ff @(posedge CLK) begin
      if (RESET || flush) begin
         reg_write_e  <= 1'b0;
         mem_to_reg_e <= 1'b0;
         mem_write_e  <= 1'b0;
         branch_e     <= 1'b0;
         jump_e       <= 1'b0;
         alu_src_e    <= 1'b0;
         alu_op_e     <= '0;
         rd1_e        <= '0;
         rd2_e        <= '0;
         imm_e        <= '0;
         shamt_e      <= '0;
         pc4_e        <= '0;
         wb_addr_e    <= '0;
      end else if (!stall) begin
         reg_write_e  <= RegWriteD;
         mem_to_reg_e <= MemtoRegD;
         mem_write_e  <= MemWriteD;
         branch_e     <= BranchD;
         jump_e       <= JumpD;
         alu_src_e    <= ALUSrcD;
         alu_op_e     <= ALUopD;
         rd1_e        <= RegData1_in;
         rd2_e        <= RegData2_in;
         imm_e        <= SignImm_in;
         shamt_e      <= shamt_in;
         pc4_e        <= PCPlus4_in;
         wb_addr_e    <= wb_addr_in;
      end
   end

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} mul_state_t;

   mul_state_t  state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] mcand, mplier, acc;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && state_nxt == ST_MUL) begin
            mcand  <= rd1_e;
            mplier <= rd2_e;
            acc    <= '0;
            cnt    <= 5'd31;
         end else if (state == ST_MUL) begin
            if (mplier[0])
               acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt != 5'd0)
               cnt <= cnt - 5'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (alu_op_e == OP_MUL) begin
               stall     = 1'b1;
               state_nxt = ST_MUL;
            end
         end
         ST_MUL: begin
            stall = 1'b1;
            if (cnt == 5'd0)
               state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (flush)
         state_nxt = ST_IDLE;
   end

   assign mul_done   = (state == ST_DONE);
   assign mul_result = acc;
`else
   assign stall      = 1'b0;
   assign mul_done   = 1'b0;
   assign mul_result = '0;
`endif

   assign src_b = alu_src_e ? imm_e : rd2_e;

   // Branch compares always use the register pair, never the immediate.
   always_comb begin
      alu_out = '0;
      case (alu_op_e)
         OP_ADD:        alu_out = rd1_e + src_b;
         OP_SUB:        alu_out = rd1_e - src_b;
         OP_AND:        alu_out = rd1_e & src_b;
         OP_OR:         alu_out = rd1_e | src_b;
         OP_XOR:        alu_out = rd1_e ^ src_b;
         OP_NOR:        alu_out = ~(rd1_e | src_b);
         OP_SLT:        alu_out = {31'd0, $signed(rd1_e) < $signed(src_b)};
         OP_SLL:        alu_out = src_b << shamt_e;
         OP_SRL:        alu_out = src_b >> shamt_e;
         OP_SRA:        alu_out = $unsigned($signed(src_b) >>> shamt_e);
         OP_BEQ:        alu_out = {31'd0, rd1_e == rd2_e};
         OP_BNE:        alu_out = {31'd0, rd1_e != rd2_e};
         OP_J, OP_JAL:  alu_out = {pc4_e[31:28], imm_e[25:0], 2'b00};
         OP_JR:         alu_out = rd1_e;
         OP_MUL:        alu_out = mul_done ? mul_result : '0;
         default:       alu_out = '0;
      endcase
   end

   assign ALUOut_out    = alu_out;
   assign PCBranch_out  = pc4_e + {imm_e[29:0], 2'b00};
   assign RegWriteE     = reg_write_e  & ~stall;
   assign MemtoRegE     = mem_to_reg_e & ~stall;
   assign MemWriteE     = mem_write_e  & ~stall;
   assign BranchE       = branch_e     & ~stall;
   assign JumpE         = jump_e       & ~stall;
   assign ALUopE        = alu_op_e;
   assign WriteData_out = rd2_e;
   assign PCPlus4_out   = pc4_e;
   assign wb_addr_out   = wb_addr_e;
endmodule
